// File: rtl/siganfu_fire_control_arbiter_if.sv
// Station request/status lines and gun control/status lines shared by the fire-control arbiter.
interface siganfu_fire_control_arbiter_if #(
    parameter int N_STATIONS = 4
);
    logic [N_STATIONS-1:0] station_req;
    logic [N_STATIONS-1:0] station_locked;
    logic [N_STATIONS-1:0] station_enemy;
    logic [N_STATIONS-1:0] station_mode;
    logic                  gun_fire_trigger;
    logic                  gun_crit_alert;
    logic                  gun_target_locked;
    logic                  gun_is_enemy;
    logic                  gun_firing_mode;
    logic                  gun_fire_command;
    logic [N_STATIONS-1:0] grant;
    logic [7:0]            rounds_fired;
    logic                  abort_pulse;

    modport master (
        output station_req, station_locked, station_enemy, station_mode,
        output gun_fire_trigger, gun_crit_alert,
        input  gun_target_locked, gun_is_enemy, gun_firing_mode, gun_fire_command,
        input  grant, rounds_fired, abort_pulse
    );

    modport slave (
        input  station_req, station_locked, station_enemy, station_mode,
        input  gun_fire_trigger, gun_crit_alert,
        output gun_target_locked, gun_is_enemy, gun_firing_mode, gun_fire_command,
        output grant, rounds_fired, abort_pulse
    );
endinterface

// File: rtl/siganfu_fire_control_arbiter.sv
// Round-robin arbiter granting one station at a time a bounded burst on the shared gun,
// with trigger counting, watchdog abort and critical-alert lockout.
module siganfu_fire_control_arbiter #(
    parameter int N_STATIONS     = 4,
    parameter int BURST_QUOTA    = 5,
    parameter int RELEASE_CYCLES = 2,
    parameter int WATCHDOG       = 40
) (
    input logic                           sysclk,
    input logic                           reboot,
    siganfu_fire_control_arbiter_if.slave bus
);
    localparam int IW   = (N_STATIONS > 1) ? $clog2(N_STATIONS) : 1;
    localparam int WD_W = $clog2(WATCHDOG + 1);
    localparam int RC_W = (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES) : 1;

    typedef enum logic [2:0] {ARB, ARM, FIRE, RELEASE, LOCKOUT} state_t;

    state_t                state_q;
    logic [IW-1:0]         rr_ptr_q;
    logic [IW-1:0]         owner_q;
    logic [N_STATIONS-1:0] grant_q;
    logic [7:0]            rounds_q;
    logic [7:0]            rounds_d;
    logic [WD_W-1:0]       wd_q;
    logic [WD_W-1:0]       wd_d;
    logic [RC_W-1:0]       rel_q;
    logic                  trig_q;
    logic                  abort_q;
    logic                  locked_q;
    logic                  enemy_q;
    logic                  mode_q;
    logic                  cmd_q;

    logic [N_STATIONS-1:0] eligible;
    logic                  win_found;
    logic [IW-1:0]         win_idx;
    logic [IW-1:0]         cand;
    logic [IW-1:0]         rr_next;
    logic                  trig_rise;
    logic                  quota_hit;
    logic                  owner_gone;
    logic                  wd_expired;
    int                    idx;

    // Scan offsets from high to low so the smallest offset from rr_ptr wins.
    always_comb begin
        eligible  = bus.station_req & bus.station_locked & bus.station_enemy;
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        idx       = 0;
        for (int k = N_STATIONS - 1; k >= 0; k--) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= N_STATIONS) idx = idx - N_STATIONS;
            cand = IW'(idx);
            if (eligible[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
        rr_next    = (win_idx == IW'(N_STATIONS - 1)) ? '0 : win_idx + IW'(1);
        trig_rise  = bus.gun_fire_trigger & ~trig_q;
        rounds_d   = (trig_rise && rounds_q != 8'hFF) ? rounds_q + 8'd1 : rounds_q;
        wd_d       = trig_rise ? '0 : wd_q + WD_W'(1);
        quota_hit  = (rounds_d >= 8'(BURST_QUOTA));
        owner_gone = ~eligible[owner_q];
        wd_expired = (wd_d == WD_W'(WATCHDOG));
    end

    always_ff @(posedge sysclk) begin
        if (reboot) begin
            state_q  <= ARB;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            grant_q  <= '0;
            rounds_q <= '0;
            wd_q     <= '0;
            rel_q    <= '0;
            trig_q   <= 1'b0;
            abort_q  <= 1'b0;
            locked_q <= 1'b0;
            enemy_q  <= 1'b0;
            mode_q   <= 1'b0;
            cmd_q    <= 1'b0;
        end else begin
            trig_q  <= bus.gun_fire_trigger;
            abort_q <= 1'b0;
            if (bus.gun_crit_alert) begin
                state_q  <= LOCKOUT;
                abort_q  <= (grant_q != '0);
                grant_q  <= '0;
                locked_q <= 1'b0;
                enemy_q  <= 1'b0;
                mode_q   <= 1'b0;
                cmd_q    <= 1'b0;
            end else begin
                case (state_q)
                    ARB: begin
                        if (win_found) begin
                            state_q  <= ARM;
                            grant_q  <= N_STATIONS'(1) << win_idx;
                            owner_q  <= win_idx;
                            rr_ptr_q <= rr_next;
                            rounds_q <= '0;
                            locked_q <= 1'b1;
                            enemy_q  <= 1'b1;
                            mode_q   <= bus.station_mode[win_idx];
                            cmd_q    <= 1'b0;
                        end
                    end
                    ARM: begin
                        state_q <= FIRE;
                        wd_q    <= '0;
                        cmd_q   <= 1'b1;
                    end
                    FIRE: begin
                        rounds_q <= rounds_d;
                        wd_q     <= wd_d;
                        if (quota_hit || owner_gone || wd_expired) begin
                            state_q  <= RELEASE;
                            rel_q    <= '0;
                            abort_q  <= ~(quota_hit || owner_gone);
                            grant_q  <= '0;
                            locked_q <= 1'b0;
                            enemy_q  <= 1'b0;
                            mode_q   <= 1'b0;
                            cmd_q    <= 1'b0;
                        end
                    end
                    RELEASE: begin
                        if (rel_q == RC_W'(RELEASE_CYCLES - 1)) state_q <= ARB;
                        else rel_q <= rel_q + RC_W'(1);
                    end
                    LOCKOUT: begin
                        state_q <= RELEASE;
                        rel_q   <= '0;
                    end
                    default: state_q <= ARB;
                endcase
            end
        end
    end

    assign bus.grant             = grant_q;
    assign bus.rounds_fired      = rounds_q;
    assign bus.abort_pulse       = abort_q;
    assign bus.gun_target_locked = locked_q;
    assign bus.gun_is_enemy      = enemy_q;
    assign bus.gun_firing_mode   = mode_q;
    assign bus.gun_fire_command  = cmd_q;
endmodule

// File: tb/tb_siganfu_fire_control_arbiter.sv
// Directed bench for the fire-control arbiter: arbitration order, bursts, lockout, watchdog, reboot.
`timescale 1ms/1us
module tb_siganfu_fire_control_arbiter;
    localparam int N     = 4;
    localparam int QUOTA = 5;
    localparam int REL   = 2;
    localparam int WD    = 40;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_pass = 0;
    int   n_fail = 0;
    int   exp_g[6] = '{1, 2, 8, 1, 2, 8};

    always #5 clk = ~clk;

    siganfu_fire_control_arbiter_if #(.N_STATIONS(N)) bus ();

    siganfu_fire_control_arbiter #(
        .N_STATIONS(N), .BURST_QUOTA(QUOTA), .RELEASE_CYCLES(REL), .WATCHDOG(WD)
    ) dut (
        .sysclk(clk),
        .reboot(rst),
        .bus   (bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_st(input logic [3:0] req, input logic [3:0] lck,
                          input logic [3:0] en, input logic [3:0] md);
        bus.station_req    = req;
        bus.station_locked = lck;
        bus.station_enemy  = en;
        bus.station_mode   = md;
    endtask

    task automatic pulse();
        bus.gun_fire_trigger = 1'b1;
        step();
        bus.gun_fire_trigger = 1'b0;
        step();
    endtask

    task automatic wait_grant(input string tag, output int cyc);
        cyc = 0;
        while (bus.grant == '0 && cyc < 100) begin
            step();
            cyc++;
        end
        chk({tag, "_grant_seen"}, 32'(bus.grant != '0), 32'd1);
    endtask

    function automatic logic [3:0] gun_vec();
        return {bus.gun_target_locked, bus.gun_is_enemy, bus.gun_firing_mode, bus.gun_fire_command};
    endfunction

    initial begin
        #(100000 * 10);
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int c;
        set_st(4'b0000, 4'b0000, 4'b0000, 4'b0000);
        bus.gun_fire_trigger = 1'b0;
        bus.gun_crit_alert   = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_grant", bus.grant, 0);
        chk("rst_gun", gun_vec(), 0);
        chk("rst_rounds", bus.rounds_fired, 0);
        chk("rst_abort", bus.abort_pulse, 0);

        // Station 1 requesting but friendly: never granted.
        set_st(4'b0010, 4'b0010, 4'b0000, 4'b0010);
        for (int i = 0; i < 12; i++) begin
            step();
            chk("t3_grant", bus.grant, 0);
            chk("t3_gun", gun_vec(), 0);
        end

        // Station 2 alone, auto mode, trigger every 10 cycles.
        set_st(4'b0100, 4'b0100, 4'b0100, 4'b0100);
        step();
        chk("t1_grant", bus.grant, 4'b0100);
        chk("t1_arm_gun", gun_vec(), 4'b1110);
        step();
        chk("t1_fc_on", bus.gun_fire_command, 1);
        for (int p = 1; p <= QUOTA; p++) begin
            bus.gun_fire_trigger = 1'b1;
            step();
            bus.gun_fire_trigger = 1'b0;
            chk("t1_rounds", bus.rounds_fired, p);
            if (p < QUOTA) begin
                chk("t1_fc_hold", bus.gun_fire_command, 1);
                repeat (9) step();
            end
        end
        chk("t1_fc_drop", bus.gun_fire_command, 0);
        chk("t1_grant_rel", bus.grant, 0);
        chk("t1_no_abort", bus.abort_pulse, 0);
        c = 0;
        while (!bus.gun_fire_command && c < 50) begin
            c++;
            step();
        end
        chk("t1_gap", 32'(c >= REL && c < 50), 1);
        chk("t1_regrant", bus.grant, 4'b0100);
        chk("t1_rounds_hold_clear", bus.rounds_fired, 0);
        set_st(4'b0000, 4'b0000, 4'b0000, 4'b0000);
        step();
        chk("t1_drop_grant", bus.grant, 0);
        chk("t1_drop_abort", bus.abort_pulse, 0);
        repeat (4) step();

        // Fresh reboot, then stations 0, 1, 3 contend.
        rst = 1'b1;
        step();
        rst = 1'b0;
        set_st(4'b1011, 4'b1011, 4'b1011, 4'b1011);
        for (int g = 0; g < 6; g++) begin
            wait_grant("t2", c);
            chk("t2_order", bus.grant, exp_g[g]);
            if (g > 0) chk("t2_gap", 32'(c >= REL), 1);
            step();
            repeat (QUOTA) pulse();
            chk("t2_rounds", bus.rounds_fired, QUOTA);
            chk("t2_release", bus.grant, 0);
        end

        // Critical alert after the 2nd round.
        wait_grant("t4", c);
        chk("t4_grant", bus.grant, 4'b0001);
        step();
        pulse();
        pulse();
        chk("t4_rounds2", bus.rounds_fired, 2);
        bus.gun_crit_alert = 1'b1;
        step();
        chk("t4_fc", bus.gun_fire_command, 0);
        chk("t4_grant0", bus.grant, 0);
        chk("t4_abort", bus.abort_pulse, 1);
        chk("t4_rounds", bus.rounds_fired, 2);
        step();
        chk("t4_abort_once", bus.abort_pulse, 0);
        repeat (3) step();
        chk("t4_lock_hold", bus.grant, 0);
        chk("t4_lock_gun", gun_vec(), 0);
        bus.gun_crit_alert = 1'b0;
        step();
        chk("t4_release", bus.grant, 0);
        wait_grant("t4b", c);
        chk("t4_next", bus.grant, 4'b0010);
        chk("t4_gap", 32'(c >= REL), 1);

        // No triggers: watchdog aborts after WD cycles in FIRE.
        step();
        c = 0;
        while (!bus.abort_pulse && c < 100) begin
            step();
            c++;
        end
        chk("t5_wd_cycles", c, WD);
        chk("t5_grant0", bus.grant, 0);
        chk("t5_fc0", bus.gun_fire_command, 0);
        step();
        chk("t5_abort_once", bus.abort_pulse, 0);
        wait_grant("t5", c);
        chk("t5_next", bus.grant, 4'b1000);

        // Reboot mid-burst; station 0 (single mode) wins first afterwards.
        set_st(4'b1011, 4'b1011, 4'b1011, 4'b1010);
        step();
        pulse();
        chk("t6_rounds", bus.rounds_fired, 1);
        rst = 1'b1;
        step();
        chk("t6_grant", bus.grant, 0);
        chk("t6_gun", gun_vec(), 0);
        chk("t6_rounds0", bus.rounds_fired, 0);
        chk("t6_abort", bus.abort_pulse, 0);
        rst = 1'b0;
        step();
        chk("t6_first", bus.grant, 4'b0001);
        chk("t6_arm_gun", gun_vec(), 4'b1100);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
